// File: rtl/fifo_packer_pkg.sv
// Shared types and helpers for the 1-bit FIFO drain/packer.
// Holds the FSM encoding, the counter-width function and partial-word alignment.
package fifo_packer_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    HOLD = 1'b1
  } pk_state_e;

  localparam int MAX_W = 32;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  // Word holds cnt captured bits in the shift register's natural position;
  // move them to the top (msb_first) or bottom of a width-bit word, zero fill.
  function automatic logic [MAX_W-1:0] align_word(input logic [MAX_W-1:0] word,
                                                  input int width,
                                                  input int cnt,
                                                  input bit msb_first);
    logic [MAX_W-1:0] mask;
    int sh;
    mask = '1;
    mask = mask >> (MAX_W - width);
    sh   = width - cnt;
    if (msb_first) begin
      return (word << sh) & mask;
    end
    return word >> sh;
  endfunction

endpackage

// File: rtl/fifo_packer_outreg.sv
// Single-entry valid/ready output register; load has priority over release.
// Latency 1 cycle from load; holds data/cnt stable while out_valid && !out_ready.
module fifo_packer_outreg #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CW-1:0]    load_cnt,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_cnt
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
      out_cnt   <= load_cnt;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_bit_packer.sv
// Drains a 1-bit FIFO and packs WIDTH bits per word, flush emits a zero-padded partial word.
// Word valid one edge after the last capture; a busy output slot parks the word in HOLD and stops reads.
module fifo_bit_packer
  import fifo_packer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  input  logic                    fifo_dout,
  output logic                    fifo_rd,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [cnt_w(WIDTH)-1:0] out_cnt
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [0:0]    ST_FILL = FILL;
  localparam logic [0:0]    ST_HOLD = HOLD;
  localparam logic [CW-1:0] FULL    = CW'(WIDTH);

  logic [0:0]       state;
  logic [CW-1:0]    iss_cnt;
  logic [CW-1:0]    cap_cnt;
  logic [CW-1:0]    hold_cnt;
  logic             rd_pend;
  logic             flush_pend;
  logic [WIDTH-1:0] sreg;

  logic             in_fill;
  logic             flush_req;
  logic [CW-1:0]    cap_next;
  logic [WIDTH-1:0] sreg_next;
  logic             word_done;
  logic             flush_svc;
  logic             emit;
  logic [CW-1:0]    emit_cnt;
  logic             slot_free;
  logic             hold_go;
  logic             load;
  logic [CW-1:0]    load_cnt;
  logic [WIDTH-1:0] load_data;

  assign in_fill   = (state == ST_FILL);
  assign fifo_rd   = in_fill && !fifo_empty && (iss_cnt < FULL) && !flush && !flush_pend;
  assign flush_req = flush || flush_pend;

  assign cap_next  = cap_cnt + CW'(rd_pend);
  assign sreg_next = !rd_pend         ? sreg :
                     (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], fifo_dout} :
                                        {fifo_dout, sreg[WIDTH-1:1]};

  // A flush waits while a bit is still in flight so that bit joins the partial word.
  assign word_done = rd_pend && (cap_next == FULL);
  assign flush_svc = in_fill && flush_req && !rd_pend;
  assign emit      = word_done || (flush_svc && (cap_cnt != '0));
  assign emit_cnt  = word_done ? FULL : cap_cnt;

  assign slot_free = !out_valid || out_ready;
  assign hold_go   = !in_fill && out_valid && out_ready;
  assign load      = (in_fill && emit && slot_free) || hold_go;
  assign load_cnt  = hold_go ? hold_cnt : emit_cnt;
  assign load_data = WIDTH'(align_word(MAX_W'(sreg_next), WIDTH, int'(load_cnt), MSB_FIRST != 0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_FILL;
      iss_cnt    <= '0;
      cap_cnt    <= '0;
      hold_cnt   <= '0;
      rd_pend    <= 1'b0;
      flush_pend <= 1'b0;
      sreg       <= '0;
    end else begin
      rd_pend <= fifo_rd;
      if (in_fill) begin
        if (emit) begin
          iss_cnt    <= '0;
          cap_cnt    <= '0;
          flush_pend <= 1'b0;
          if (slot_free) begin
            sreg <= '0;
          end else begin
            sreg     <= sreg_next;
            hold_cnt <= emit_cnt;
            state    <= ST_HOLD;
          end
        end else if (flush_svc) begin
          iss_cnt    <= '0;
          cap_cnt    <= '0;
          flush_pend <= 1'b0;
        end else begin
          if (fifo_rd) begin
            iss_cnt <= iss_cnt + CW'(1);
          end
          cap_cnt <= cap_next;
          sreg    <= sreg_next;
          if (flush) begin
            flush_pend <= 1'b1;
          end
        end
      end else begin
        if (flush) begin
          flush_pend <= 1'b1;
        end
        if (hold_go) begin
          state   <= ST_FILL;
          sreg    <= '0;
          iss_cnt <= '0;
          cap_cnt <= '0;
        end
      end
    end
  end

  fifo_packer_outreg #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_cnt  (load_cnt),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
  );

endmodule
